// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball motion block: state encoding,
// direction constants and the serve-position calculation.
package ball_pkg;

   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      MOVING = 2'd1,
      LOST   = 2'd2
   } state_t;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   // Centre the ball over the paddle, keeping it fully inside the field
   // even when the paddle hangs over either edge.
   function automatic int centerClamp(input int padX, input int padW,
                                      input int size, input int fieldMax);
      int center;
      center = padX + padW / 2 - size / 2;
      if (center < 0) begin
         center = 0;
      end else if (center > fieldMax - size) begin
         center = fieldMax - size;
      end
      return center;
   endfunction

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: optional direction flip, then a step of
// 'speed' pixels with clamping against the low and high bounds.
module ball_axis
   import ball_pkg::*;
#(
   parameter int W     = 10,
   parameter int SPD_W = 3
) (
   input  logic [W-1:0]     pos_i,
   input  logic             dir_i,
   input  logic [SPD_W-1:0] speed_i,
   input  logic [W-1:0]     lo_i,
   input  logic [W-1:0]     hi_i,
   input  logic             stepEn_i,
   input  logic             forceFlip_i,
   output logic [W-1:0]     posNext_o,
   output logic             dirNext_o,
   output logic             hitHi_o
);

   localparam int WP = W + 1;

   logic [W:0] speedWide;
   logic [W:0] posPlus;
   logic [W:0] loPlus;
   logic       dirEff;

   // One extra bit keeps the compares free of wrap-around.
   assign speedWide = WP'(speed_i);
   assign posPlus   = {1'b0, pos_i} + speedWide;
   assign loPlus    = {1'b0, lo_i} + speedWide;
   assign dirEff    = dir_i ^ (stepEn_i & forceFlip_i);

   // Flip first, then step; a clamp always turns the ball back into the field.
   always_comb begin
      posNext_o = pos_i;
      dirNext_o = dir_i;
      hitHi_o   = 1'b0;
      if (stepEn_i) begin
         dirNext_o = dirEff;
         if (speed_i != '0) begin
            if (dirEff == DIR_INC) begin
               if (posPlus >= {1'b0, hi_i}) begin
                  posNext_o = hi_i;
                  dirNext_o = DIR_DEC;
                  hitHi_o   = 1'b1;
               end else begin
                  posNext_o = posPlus[W-1:0];
               end
            end else begin
               if ({1'b0, pos_i} <= loPlus) begin
                  posNext_o = lo_i;
                  dirNext_o = DIR_INC;
               end else begin
                  posNext_o = pos_i - W'(speed_i);
               end
            end
         end
      end
   end

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction owner: serve tracking, per-tick motion with
// wall, paddle and brick bounces, and loss detection at the bottom.
module ball_motion
   import ball_pkg::*;
#(
   parameter int W     = 10,
   parameter int X_MAX = 640,
   parameter int Y_MAX = 480,
   parameter int SIZE  = 4,
   parameter int SPD_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tick,
   input  logic             launch,
   input  logic [SPD_W-1:0] speed,
   input  logic [W-1:0]     paddle_x,
   input  logic [W-1:0]     paddle_y,
   input  logic [W-1:0]     paddle_w,
   input  logic             brick_hit,
   input  logic             brick_side,
   output logic [W-1:0]     x,
   output logic [W-1:0]     y,
   output logic             x_dir,
   output logic             y_dir,
   output logic             moving,
   output logic             lost
);

   localparam int WP = W + 1;
   localparam logic [W-1:0]  X_HI    = W'(X_MAX - SIZE);
   localparam logic [W-1:0]  Y_HI    = W'(Y_MAX - SIZE);
   localparam logic [W-1:0]  SIZE_N  = W'(SIZE);
   localparam logic [WP-1:0] SIZE_WP = WP'(SIZE);

   state_t     state_q, state_d;
   logic [W-1:0] xPos_q, xPos_d, yPos_q, yPos_d;
   logic       xDir_q, xDir_d, yDir_q, yDir_d;
   logic       moving_q, moving_d, lost_q, lost_d;
   logic       brickPend_q, brickPend_d, brickSide_q, brickSide_d;

   logic         stepEn, flipX, flipY, yDirEff, paddleHit;
   logic [W-1:0] serveX, serveY, xNext, yNext;
   logic         xDirNext, yDirNext, xHitHi, yHitHi;
   logic [W:0]   speedWide, yBottom;

   assign stepEn    = tick & (state_q == MOVING);
   assign flipX     = brickPend_q & brickSide_q;
   assign flipY     = brickPend_q & ~brickSide_q;
   assign yDirEff   = yDir_q ^ flipY;
   assign serveX    = W'(centerClamp(int'(paddle_x), int'(paddle_w), SIZE, X_MAX));
   assign serveY    = paddle_y - SIZE_N;
   assign speedWide = WP'(speed);
   assign yBottom   = {1'b0, yPos_q} + SIZE_WP;
   assign paddleHit = (yBottom <= {1'b0, paddle_y})
                   && (yBottom + speedWide >= {1'b0, paddle_y})
                   && ({1'b0, xPos_q} + SIZE_WP > {1'b0, paddle_x})
                   && ({1'b0, xPos_q} < {1'b0, paddle_x} + {1'b0, paddle_w});

   ball_axis #(.W(W), .SPD_W(SPD_W)) xAxis (
      .pos_i      (xPos_q),
      .dir_i      (xDir_q),
      .speed_i    (speed),
      .lo_i       ('0),
      .hi_i       (X_HI),
      .stepEn_i   (stepEn),
      .forceFlip_i(flipX),
      .posNext_o  (xNext),
      .dirNext_o  (xDirNext),
      .hitHi_o    (xHitHi)
   );

   ball_axis #(.W(W), .SPD_W(SPD_W)) yAxis (
      .pos_i      (yPos_q),
      .dir_i      (yDir_q),
      .speed_i    (speed),
      .lo_i       ('0),
      .hi_i       (Y_HI),
      .stepEn_i   (stepEn),
      .forceFlip_i(flipY),
      .posNext_o  (yNext),
      .dirNext_o  (yDirNext),
      .hitHi_o    (yHitHi)
   );

   // Next-state logic: serve tracking, per-tick motion, paddle-over-bottom priority.
   always_comb begin
      state_d     = state_q;
      xPos_d      = xPos_q;
      yPos_d      = yPos_q;
      xDir_d      = xDir_q;
      yDir_d      = yDir_q;
      lost_d      = 1'b0;
      brickPend_d = brickPend_q;
      brickSide_d = brickSide_q;
      case (state_q)
         SERVE: begin
            xPos_d      = serveX;
            yPos_d      = serveY;
            brickPend_d = 1'b0;
            if (launch) begin
               state_d = MOVING;
               xDir_d  = DIR_INC;
               yDir_d  = DIR_DEC;
            end
         end
         MOVING: begin
            if (tick) begin
               xPos_d = xNext;
               xDir_d = xHitHi ? DIR_DEC : xDirNext;
               if ((speed != '0) && (yDirEff == DIR_INC) && paddleHit) begin
                  yPos_d = paddle_y - SIZE_N;
                  yDir_d = DIR_DEC;
               end else if ((yDirEff == DIR_INC) && yHitHi) begin
                  yPos_d  = yNext;
                  yDir_d  = yDirEff;
                  state_d = LOST;
                  lost_d  = 1'b1;
               end else begin
                  yPos_d = yNext;
                  yDir_d = yDirNext;
               end
               brickPend_d = brick_hit;
            end else if (brick_hit) begin
               brickPend_d = 1'b1;
            end
            if (brick_hit) begin
               brickSide_d = brick_side;
            end
         end
         LOST: begin
            brickPend_d = 1'b0;
            if (launch) begin
               state_d = SERVE;
            end
         end
         default: begin
            state_d = SERVE;
         end
      endcase
      moving_d = (state_d == MOVING);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= SERVE;
         xPos_q      <= '0;
         yPos_q      <= '0;
         xDir_q      <= DIR_INC;
         yDir_q      <= DIR_DEC;
         moving_q    <= 1'b0;
         lost_q      <= 1'b0;
         brickPend_q <= 1'b0;
         brickSide_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         xPos_q      <= xPos_d;
         yPos_q      <= yPos_d;
         xDir_q      <= xDir_d;
         yDir_q      <= yDir_d;
         moving_q    <= moving_d;
         lost_q      <= lost_d;
         brickPend_q <= brickPend_d;
         brickSide_q <= brickSide_d;
      end
   end

   assign x      = xPos_q;
   assign y      = yPos_q;
   assign x_dir  = xDir_q;
   assign y_dir  = yDir_q;
   assign moving = moving_q;
   assign lost   = lost_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: table of serve/launch vectors, hand-built corner
// sequences and a randomized run, all against a behavioural game model.
module tb_ball_motion;

   localparam int XHI = 636;
   localparam int YHI = 476;
   localparam int M_SERVE = 0;
   localparam int M_MOVE  = 1;
   localparam int M_LOST  = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic       launch = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [9:0] paddle_x = 10'd300;
   logic [9:0] paddle_y = 10'd460;
   logic [9:0] paddle_w = 10'd40;
   logic       brick_hit = 1'b0;
   logic       brick_side = 1'b0;
   logic [9:0] x, y;
   logic       x_dir, y_dir, moving, lost;

   int checks = 0;
   int passes = 0;

   // Game model: mode, position, directions, pending brick flip.
   int mMode = M_SERVE;
   int mX = 0, mY = 0, mXd = 1, mYd = 0, mLost = 0, mPend = 0, mSide = 0;

   typedef struct {
      bit launch;
      bit tick;
      int spd;
      int px;
      int expX;
      int expY;
      int expMoving;
   } vec_t;

   vec_t vecs[13];

   ball_motion dut (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .launch    (launch),
      .speed     (speed),
      .paddle_x  (paddle_x),
      .paddle_y  (paddle_y),
      .paddle_w  (paddle_w),
      .brick_hit (brick_hit),
      .brick_side(brick_side),
      .x         (x),
      .y         (y),
      .x_dir     (x_dir),
      .y_dir     (y_dir),
      .moving    (moving),
      .lost      (lost)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Advance the model by one clock using the current inputs.
   task automatic modelStep();
      int s, c, ox, py, px, pw;
      s  = int'(speed);
      px = int'(paddle_x);
      py = int'(paddle_y);
      pw = int'(paddle_w);
      mLost = 0;
      if (!resetn) begin
         mMode = M_SERVE; mX = 0; mY = 0; mXd = 1; mYd = 0; mPend = 0;
         return;
      end
      if (mMode == M_SERVE) begin
         c = px + pw / 2 - 2;
         if (c < 0) c = 0;
         if (c > XHI) c = XHI;
         mX = c;
         mY = (py - 4) & 1023;
         mPend = 0;
         if (launch) begin mMode = M_MOVE; mXd = 1; mYd = 0; end
      end else if (mMode == M_MOVE) begin
         if (tick) begin
            if (mPend == 1) begin
               if (mSide == 1) mXd = 1 - mXd;
               else mYd = 1 - mYd;
            end
            if (s > 0) begin
               ox = mX;
               if (mXd == 1) begin
                  if (mX + s >= XHI) begin mX = XHI; mXd = 0; end
                  else mX = mX + s;
               end else begin
                  if (mX <= s) begin mX = 0; mXd = 1; end
                  else mX = mX - s;
               end
               if (mYd == 1) begin
                  if (mY + 4 <= py && mY + 4 + s >= py && ox + 4 > px && ox < px + pw) begin
                     mY = py - 4; mYd = 0;
                  end else if (mY + s >= YHI) begin
                     mY = YHI; mMode = M_LOST; mLost = 1;
                  end else mY = mY + s;
               end else begin
                  if (mY <= s) begin mY = 0; mYd = 1; end
                  else mY = mY - s;
               end
            end
            mPend = brick_hit ? 1 : 0;
            if (brick_hit) mSide = brick_side ? 1 : 0;
         end else if (brick_hit) begin
            mPend = 1;
            mSide = brick_side ? 1 : 0;
         end
      end else begin
         mPend = 0;
         if (launch) mMode = M_SERVE;
      end
   endtask

   task automatic checkOutput();
      checkVal("model.x", int'(x), mX);
      checkVal("model.y", int'(y), mY);
      checkVal("model.x_dir", int'(x_dir), mXd);
      checkVal("model.y_dir", int'(y_dir), mYd);
      checkVal("model.moving", int'(moving), (mMode == M_MOVE) ? 1 : 0);
      checkVal("model.lost", int'(lost), mLost);
   endtask

   // One clock: predict, clock, sample 1 time unit after the edge, compare.
   task automatic applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doTick(input int s);
      tick = 1'b1;
      speed = 3'(s);
      applyStimulus();
      tick = 1'b0;
   endtask

   task automatic pulseBrick(input bit side);
      brick_hit = 1'b1;
      brick_side = side;
      applyStimulus();
      brick_hit = 1'b0;
   endtask

   task automatic doLaunch();
      launch = 1'b1;
      applyStimulus();
      launch = 1'b0;
   endtask

   task automatic resetDut();
      resetn = 1'b0;
      applyStimulus();
      applyStimulus();
      resetn = 1'b1;
   endtask

   initial begin
      int sawLost;

      // Serve tracking, launch, then ten ticks at speed 3.
      vecs[0] = '{0, 0, 0, 300, 318, 456, 0};
      vecs[1] = '{0, 0, 0, 100, 118, 456, 0};
      vecs[2] = '{1, 0, 0, 300, 318, 456, 1};
      for (int k = 1; k <= 10; k++) vecs[2 + k] = '{0, 1, 3, 300, 318 + 3 * k, 456 - 3 * k, 1};

      resetDut();
      checkVal("reset.x", int'(x), 0);
      checkVal("reset.y", int'(y), 0);
      checkVal("reset.x_dir", int'(x_dir), 1);
      checkVal("reset.y_dir", int'(y_dir), 0);
      checkVal("reset.moving", int'(moving), 0);
      checkVal("reset.lost", int'(lost), 0);

      for (int i = 0; i < 13; i++) begin
         launch = vecs[i].launch;
         tick = vecs[i].tick;
         speed = 3'(vecs[i].spd);
         paddle_x = 10'(vecs[i].px);
         applyStimulus();
         checkVal($sformatf("vec%0d.x", i), int'(x), vecs[i].expX);
         checkVal($sformatf("vec%0d.y", i), int'(y), vecs[i].expY);
         checkVal($sformatf("vec%0d.moving", i), int'(moving), vecs[i].expMoving);
         checkVal($sformatf("vec%0d.dirs", i), int'({x_dir, y_dir}), 2);
      end
      launch = 1'b0;
      tick = 1'b0;

      // Right-wall overshoot clamps and turns around.
      paddle_x = 10'd616;
      resetDut();
      applyStimulus();
      checkVal("rwall.serveX", int'(x), 634);
      doLaunch();
      doTick(5);
      checkVal("rwall.x", int'(x), 636);
      checkVal("rwall.x_dir", int'(x_dir), 0);
      doTick(5);
      checkVal("rwall.back", int'(x), 631);

      // Top-left corner: both axes bounce in the same cycle.
      paddle_x = 10'd0; paddle_w = 10'd8; paddle_y = 10'd5;
      resetDut();
      applyStimulus();
      doLaunch();
      pulseBrick(1'b1);
      doTick(0);
      checkVal("corner.preflip", int'(x_dir), 0);
      doTick(4);
      checkVal("corner.x", int'(x), 0);
      checkVal("corner.y", int'(y), 0);
      checkVal("corner.x_dir", int'(x_dir), 1);
      checkVal("corner.y_dir", int'(y_dir), 1);

      // Brick flip drives the ball into the left wall; the wall wins.
      paddle_y = 10'd100;
      resetDut();
      applyStimulus();
      doLaunch();
      pulseBrick(1'b1);
      doTick(4);
      checkVal("brickwall.x", int'(x), 0);
      checkVal("brickwall.x_dir", int'(x_dir), 1);

      // Paddle hit (case A).
      paddle_x = 10'd290; paddle_w = 10'd40; paddle_y = 10'd460;
      resetDut();
      applyStimulus();
      doLaunch();
      doTick(1);
      doTick(1);
      paddle_x = 10'd300;
      pulseBrick(1'b0);
      doTick(0);
      checkVal("paddleA.pre", int'(y), 454);
      doTick(3);
      checkVal("paddleA.y", int'(y), 456);
      checkVal("paddleA.y_dir", int'(y_dir), 0);

      // Paddle miss (case B): ball falls to the bottom and is lost.
      paddle_x = 10'd180;
      resetDut();
      applyStimulus();
      doLaunch();
      doTick(1);
      doTick(1);
      paddle_x = 10'd300;
      pulseBrick(1'b0);
      doTick(0);
      sawLost = 0;
      for (int t = 0; t < 20 && sawLost == 0; t++) begin
         doTick(3);
         if (lost) sawLost = 1;
      end
      checkVal("missB.lostSeen", sawLost, 1);
      checkVal("missB.y", int'(y), 476);
      checkVal("missB.moving", int'(moving), 0);
      applyStimulus();
      checkVal("missB.lostPulse", int'(lost), 0);
      doLaunch();
      applyStimulus();
      checkVal("missB.reserveX", int'(x), 318);
      checkVal("missB.reserveY", int'(y), 456);

      // Brick flips: early report, merge, and same-cycle-as-tick.
      resetDut();
      applyStimulus();
      doLaunch();
      pulseBrick(1'b1);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      doTick(2);
      checkVal("brick.x", int'(x), 316);
      checkVal("brick.x_dir", int'(x_dir), 0);
      pulseBrick(1'b1);
      pulseBrick(1'b0);
      doTick(1);
      checkVal("brickMerge.x_dir", int'(x_dir), 0);
      checkVal("brickMerge.y_dir", int'(y_dir), 1);
      brick_hit = 1'b1; brick_side = 1'b1;
      doTick(1);
      brick_hit = 1'b0;
      checkVal("brickSame.x_dir", int'(x_dir), 0);
      doTick(1);
      checkVal("brickSame.later", int'(x_dir), 1);

      // Reset in mid-flight.
      resetn = 1'b0;
      applyStimulus();
      resetn = 1'b1;
      checkVal("midReset.x", int'(x), 0);
      checkVal("midReset.y", int'(y), 0);
      checkVal("midReset.x_dir", int'(x_dir), 1);
      checkVal("midReset.moving", int'(moving), 0);

      // Randomized play against the model.
      for (int i = 0; i < 4000; i++) begin
         if (i % 50 == 0) begin
            paddle_x = 10'($urandom_range(0, 639));
            paddle_w = 10'($urandom_range(8, 120));
            paddle_y = 10'($urandom_range(300, 470));
         end
         launch = ($urandom_range(0, 19) == 0);
         tick = ($urandom_range(0, 3) == 0);
         speed = 3'($urandom_range(0, 7));
         brick_hit = ($urandom_range(0, 9) == 0);
         brick_side = 1'($urandom_range(0, 1));
         resetn = ($urandom_range(0, 499) != 0);
         applyStimulus();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
